// File: rtl/decode_stage_reg_if.sv
// rtl/decode_stage_reg_if.sv - IF/ID, writeback and ID/EX signal bundle for the decode stage
interface decode_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
);
  localparam int ADDR_W = $clog2(NREG);

  logic                   i_valid;
  logic [31:0]            i_instruction;
  logic [DATA_W-1:0]      i_pc;
  logic                   i_wb_we;
  logic [ADDR_W-1:0]      i_wb_addr;
  logic [DATA_W-1:0]      i_wb_data;
  logic                   i_flush;
  logic                   i_ex_stall;

  logic                   o_valid;
  logic [ADDR_W-1:0]      o_rs_addr;
  logic [ADDR_W-1:0]      o_rt_addr;
  logic [ADDR_W-1:0]      o_rd_addr;
  logic [DATA_W-1:0]      o_rs_data;
  logic [DATA_W-1:0]      o_rt_data;
  logic [DATA_W-1:0]      o_imm;
  logic [DATA_W-1:0]      o_pc;
  logic [5:0]             o_op;
  logic [5:0]             o_funct;
  logic                   o_reg_dst;
  logic                   o_alu_src;
  logic                   o_mem_read;
  logic                   o_mem_write;
  logic                   o_reg_write;
  logic                   o_pc_write;
  logic                   o_if_id_write;
  logic [15:0]            o_stall_count;
  logic [NREG*DATA_W-1:0] o_registers;

  modport master (
    output i_valid, i_instruction, i_pc, i_wb_we, i_wb_addr, i_wb_data, i_flush, i_ex_stall,
    input  o_valid, o_rs_addr, o_rt_addr, o_rd_addr, o_rs_data, o_rt_data, o_imm, o_pc,
           o_op, o_funct, o_reg_dst, o_alu_src, o_mem_read, o_mem_write, o_reg_write,
           o_pc_write, o_if_id_write, o_stall_count, o_registers
  );

  modport slave (
    input  i_valid, i_instruction, i_pc, i_wb_we, i_wb_addr, i_wb_data, i_flush, i_ex_stall,
    output o_valid, o_rs_addr, o_rt_addr, o_rd_addr, o_rs_data, o_rt_data, o_imm, o_pc,
           o_op, o_funct, o_reg_dst, o_alu_src, o_mem_read, o_mem_write, o_reg_write,
           o_pc_write, o_if_id_write, o_stall_count, o_registers
  );
endinterface

// File: rtl/decode_stage_reg.sv
// rtl/decode_stage_reg.sv - MIPS decode stage: register file, control decode, load-use hazard, ID/EX register
module decode_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int NREG       = 32,
  parameter int FORWARD_WB = 1
) (
  input  logic                clk,
  input  logic                i_reset,
  decode_stage_reg_if.slave   bus
);
  localparam int ADDR_W = $clog2(NREG);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [5:0]        op;
    logic [5:0]        funct;
    logic              reg_dst;
    logic              alu_src;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
  } idex_t;

  logic [DATA_W-1:0] regs_q [NREG];
  idex_t             idex_q, idex_d, dec;
  logic [15:0]       count_q, count_d;

  logic [ADDR_W-1:0] rs_addr, rt_addr, rd_addr;
  logic [DATA_W-1:0] rs_data, rt_data;
  logic [5:0]        op;
  logic              hazard;
  logic              stall_up;
  logic [NREG*DATA_W-1:0] regs_flat;
  logic              unused_instr_bits;

  assign op      = bus.i_instruction[31:26];
  assign rs_addr = bus.i_instruction[21 +: ADDR_W];
  assign rt_addr = bus.i_instruction[16 +: ADDR_W];
  assign rd_addr = bus.i_instruction[11 +: ADDR_W];
  assign unused_instr_bits = ^bus.i_instruction[10:6];

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
    end else if (bus.i_wb_we && (bus.i_wb_addr != '0)) begin
      regs_q[bus.i_wb_addr] <= bus.i_wb_data;
    end
  end

  always_comb begin
    rs_data = regs_q[rs_addr];
    if (rs_addr == '0) begin
      rs_data = '0;
    end else if ((FORWARD_WB != 0) && bus.i_wb_we && (bus.i_wb_addr == rs_addr)) begin
      rs_data = bus.i_wb_data;
    end
  end

  always_comb begin
    rt_data = regs_q[rt_addr];
    if (rt_addr == '0) begin
      rt_data = '0;
    end else if ((FORWARD_WB != 0) && bus.i_wb_we && (bus.i_wb_addr == rt_addr)) begin
      rt_data = bus.i_wb_data;
    end
  end

  always_comb begin
    dec         = '0;
    dec.valid   = 1'b1;
    dec.rs      = rs_addr;
    dec.rt      = rt_addr;
    dec.rd      = rd_addr;
    dec.rs_data = rs_data;
    dec.rt_data = rt_data;
    dec.imm     = {{(DATA_W-16){bus.i_instruction[15]}}, bus.i_instruction[15:0]};
    dec.pc      = bus.i_pc;
    dec.op      = op;
    dec.funct   = bus.i_instruction[5:0];
    case (op)
      6'b000000: begin dec.reg_dst  = 1'b1; dec.reg_write = 1'b1; end
      6'b100011: begin dec.mem_read = 1'b1; dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
      6'b101011: begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; end
      6'b001000: begin dec.alu_src  = 1'b1; dec.reg_write = 1'b1; end
      default: ;
    endcase
  end

  // A load in EX whose destination feeds this instruction must wait one cycle.
  assign hazard = bus.i_valid && idex_q.valid && idex_q.mem_read && (idex_q.rt != '0) &&
                  ((idex_q.rt == rs_addr) || (idex_q.rt == rt_addr));

  assign stall_up = bus.i_ex_stall || (hazard && !bus.i_flush);

  always_comb begin
    idex_d = idex_q;
    if (bus.i_ex_stall) begin
      idex_d = idex_q;
    end else if (bus.i_flush || hazard || !bus.i_valid) begin
      idex_d = '0;
    end else begin
      idex_d = dec;
    end
  end

  always_comb begin
    count_d = count_q;
    if (hazard && !bus.i_flush && !bus.i_ex_stall && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      idex_q  <= '0;
      count_q <= '0;
    end else begin
      idex_q  <= idex_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int k = 0; k < NREG; k++) regs_flat[k*DATA_W +: DATA_W] = regs_q[k];
  end

  assign bus.o_valid       = idex_q.valid;
  assign bus.o_rs_addr     = idex_q.rs;
  assign bus.o_rt_addr     = idex_q.rt;
  assign bus.o_rd_addr     = idex_q.rd;
  assign bus.o_rs_data     = idex_q.rs_data;
  assign bus.o_rt_data     = idex_q.rt_data;
  assign bus.o_imm         = idex_q.imm;
  assign bus.o_pc          = idex_q.pc;
  assign bus.o_op          = idex_q.op;
  assign bus.o_funct       = idex_q.funct;
  assign bus.o_reg_dst     = idex_q.reg_dst;
  assign bus.o_alu_src     = idex_q.alu_src;
  assign bus.o_mem_read    = idex_q.mem_read;
  assign bus.o_mem_write   = idex_q.mem_write;
  assign bus.o_reg_write   = idex_q.reg_write;
  assign bus.o_pc_write    = !stall_up;
  assign bus.o_if_id_write = !stall_up;
  assign bus.o_stall_count = count_q;
  assign bus.o_registers   = regs_flat;
endmodule

// File: tb/tb_decode_stage_reg.sv
// tb/tb_decode_stage_reg.sv - randomized bench for decode_stage_reg against a behavioural model, both bypass settings
module tb_decode_stage_reg;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        t_valid;
  logic [31:0] t_instr;
  logic [31:0] t_pc;
  logic        t_wb_we;
  logic [4:0]  t_wb_addr;
  logic [31:0] t_wb_data;
  logic        t_flush;
  logic        t_stall;

  decode_stage_reg_if #(.DATA_W(DATA_W), .NREG(NREG)) b0 ();
  decode_stage_reg_if #(.DATA_W(DATA_W), .NREG(NREG)) b1 ();

  assign b0.i_valid = t_valid;       assign b1.i_valid = t_valid;
  assign b0.i_instruction = t_instr; assign b1.i_instruction = t_instr;
  assign b0.i_pc = t_pc;             assign b1.i_pc = t_pc;
  assign b0.i_wb_we = t_wb_we;       assign b1.i_wb_we = t_wb_we;
  assign b0.i_wb_addr = t_wb_addr;   assign b1.i_wb_addr = t_wb_addr;
  assign b0.i_wb_data = t_wb_data;   assign b1.i_wb_data = t_wb_data;
  assign b0.i_flush = t_flush;       assign b1.i_flush = t_flush;
  assign b0.i_ex_stall = t_stall;    assign b1.i_ex_stall = t_stall;

  decode_stage_reg #(.DATA_W(DATA_W), .NREG(NREG), .FORWARD_WB(1)) dut_fwd (
    .clk(clk), .i_reset(rst), .bus(b0));
  decode_stage_reg #(.DATA_W(DATA_W), .NREG(NREG), .FORWARD_WB(0)) dut_nofwd (
    .clk(clk), .i_reset(rst), .bus(b1));

  // Expected ID/EX contents; ctl = {reg_dst, alu_src, mem_read, mem_write, reg_write}
  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_f, rs_n, rt_f, rt_n, imm, pc;
    logic [5:0]  op, funct;
    logic [4:0]  ctl;
  } exp_t;

  exp_t        m;
  logic [31:0] m_regs [NREG];
  int unsigned m_count;
  int          nchk = 0;
  int          nerr = 0;

  function automatic logic [4:0] ctl_of(input logic [5:0] op);
    case (op)
      6'd0:    return 5'b10001;
      6'd35:   return 5'b01101;
      6'd43:   return 5'b01010;
      6'd8:    return 5'b01001;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit fwd);
    if (a == 5'd0) return 32'd0;
    if (fwd && t_wb_we && t_wb_addr == a) return t_wb_data;
    return m_regs[a];
  endfunction

  function automatic bit m_hazard();
    logic [4:0] rs, rt;
    rs = t_instr[25:21];
    rt = t_instr[20:16];
    return t_valid && m.valid && m.ctl[2] && (m.rt != 5'd0) && (m.rt == rs || m.rt == rt);
  endfunction

  function automatic exp_t m_next();
    exp_t n;
    n = '0;
    if (t_stall) return m;
    if (t_flush || m_hazard() || !t_valid) return n;
    n.valid = 1'b1;
    n.rs    = t_instr[25:21];
    n.rt    = t_instr[20:16];
    n.rd    = t_instr[15:11];
    n.rs_f  = m_read(n.rs, 1'b1);
    n.rs_n  = m_read(n.rs, 1'b0);
    n.rt_f  = m_read(n.rt, 1'b1);
    n.rt_n  = m_read(n.rt, 1'b0);
    n.imm   = {{16{t_instr[15]}}, t_instr[15:0]};
    n.pc    = t_pc;
    n.op    = t_instr[31:26];
    n.funct = t_instr[5:0];
    n.ctl   = ctl_of(n.op);
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m       <= '0;
      m_count <= 0;
      for (int k = 0; k < NREG; k++) m_regs[k] <= 32'd0;
    end else begin
      m <= m_next();
      if (m_hazard() && !t_flush && !t_stall && m_count < 32'd65535) m_count <= m_count + 1;
      if (t_wb_we && t_wb_addr != 5'd0) m_regs[t_wb_addr] <= t_wb_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      if (nerr <= 40) $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check_all();
    logic pw;
    pw = !(t_stall || (m_hazard() && !t_flush));
    chk("pc_write", b0.o_pc_write, pw);
    chk("if_id_write", b0.o_if_id_write, pw);
    chk("pc_write_nf", b1.o_pc_write, pw);
    chk("valid", b0.o_valid, m.valid);
    chk("valid_nf", b1.o_valid, m.valid);
    chk("rs_addr", b0.o_rs_addr, m.rs);
    chk("rt_addr", b0.o_rt_addr, m.rt);
    chk("rd_addr", b0.o_rd_addr, m.rd);
    chk("rs_data", b0.o_rs_data, m.rs_f);
    chk("rt_data", b0.o_rt_data, m.rt_f);
    chk("rs_data_nf", b1.o_rs_data, m.rs_n);
    chk("rt_data_nf", b1.o_rt_data, m.rt_n);
    chk("imm", b0.o_imm, m.imm);
    chk("pc", b0.o_pc, m.pc);
    chk("op", b0.o_op, m.op);
    chk("funct", b0.o_funct, m.funct);
    chk("ctl", {b0.o_reg_dst, b0.o_alu_src, b0.o_mem_read, b0.o_mem_write, b0.o_reg_write}, m.ctl);
    chk("ctl_nf", {b1.o_reg_dst, b1.o_alu_src, b1.o_mem_read, b1.o_mem_write, b1.o_reg_write}, m.ctl);
    chk("stall_count", b0.o_stall_count, m_count);
    chk("stall_count_nf", b1.o_stall_count, m_count);
    for (int k = 0; k < NREG; k++)
      chk($sformatf("reg%0d", k), b0.o_registers[k*DATA_W +: DATA_W], m_regs[k]);
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
  endtask

  task automatic setin(input logic v, input logic [31:0] ins, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic fl, input logic st, input logic r);
    t_valid = v; t_instr = ins; t_pc = $urandom; t_wb_we = we; t_wb_addr = wa;
    t_wb_data = wd; t_flush = fl; t_stall = st; rst = r;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    setin(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    chk("rst_valid", b0.o_valid, 32'd0);
    chk("rst_count", b0.o_stall_count, 32'd0);
    setin(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    #1 chk("rst_pc_write", b0.o_pc_write, 32'd1);

    // writeback then add r3,r5,r0
    setin(1'b0, 32'd0, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 1'b0); tick();
    setin(1'b1, rtype(5'd5, 5'd0, 5'd3, 6'h20), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0); tick();
    chk("add_rs_data", b0.o_rs_data, 32'h1234);
    chk("add_reg_write", b0.o_reg_write, 32'd1);
    chk("add_reg_dst", b0.o_reg_dst, 32'd1);
    chk("add_valid", b0.o_valid, 32'd1);

    // same-cycle writeback bypass
    setin(1'b0, 32'd0, 1'b1, 5'd7, 32'h1111, 1'b0, 1'b0, 1'b0); tick();
    setin(1'b1, rtype(5'd7, 5'd0, 5'd8, 6'h20), 1'b1, 5'd7, 32'hBEEF, 1'b0, 1'b0, 1'b0); tick();
    chk("fwd_rs_data", b0.o_rs_data, 32'hBEEF);
    chk("nofwd_rs_data", b1.o_rs_data, 32'h1111);
    chk("r7_written", b0.o_registers[7*DATA_W +: DATA_W], 32'hBEEF);

    // lw r2,4(r1); add r4,r2,r3
    setin(1'b1, itype(6'd35, 5'd1, 5'd2, 16'd4), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0); tick();
    chk("lw_imm", b0.o_imm, 32'd4);
    setin(1'b1, rtype(5'd2, 5'd3, 5'd4, 6'h20), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    #1 chk("lu_pc_write", b0.o_pc_write, 32'd0);
    chk("lu_if_id_write", b0.o_if_id_write, 32'd0);
    tick();
    chk("lu_bubble", b0.o_valid, 32'd0);
    chk("lu_count", b0.o_stall_count, 32'd1);
    #1 chk("lu_pc_write_after", b0.o_pc_write, 32'd1);
    tick();
    chk("lu_add_valid", b0.o_valid, 32'd1);
    chk("lu_add_rs", b0.o_rs_addr, 32'd2);

    // lw r0 then add r4,r0,r0 with writeback to r0
    setin(1'b1, itype(6'd35, 5'd1, 5'd0, 16'd0), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0); tick();
    setin(1'b1, rtype(5'd0, 5'd0, 5'd4, 6'h20), 1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    #1 chk("r0_no_stall", b0.o_pc_write, 32'd1);
    tick();
    chk("r0_valid", b0.o_valid, 32'd1);
    chk("r0_rs_data", b0.o_rs_data, 32'd0);
    chk("r0_reg", b0.o_registers[31:0], 32'd0);
    chk("r0_count", b0.o_stall_count, 32'd1);

    // flush held under EX stall, then applied
    setin(1'b1, itype(6'd8, 5'd1, 5'd9, 16'hFFFF), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0); tick();
    chk("addi_imm_sext", b0.o_imm, 32'hFFFF_FFFF);
    setin(1'b1, rtype(5'd1, 5'd1, 5'd1, 6'h20), 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    #1 chk("stall_pc_write", b0.o_pc_write, 32'd0);
    tick(); tick();
    chk("stall_hold_valid", b0.o_valid, 32'd1);
    chk("stall_hold_op", b0.o_op, 32'd8);
    setin(1'b1, rtype(5'd1, 5'd1, 5'd1, 6'h20), 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0); tick();
    chk("flush_bubble", b0.o_valid, 32'd0);
    chk("flush_ctl", b0.o_reg_write, 32'd0);

    // reset during a load-use hazard
    setin(1'b1, itype(6'd35, 5'd1, 5'd2, 16'd4), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0); tick();
    setin(1'b1, rtype(5'd2, 5'd3, 5'd4, 6'h20), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    #1 chk("rh_pc_write_pre", b0.o_pc_write, 32'd0);
    tick();
    chk("rh_valid", b0.o_valid, 32'd0);
    chk("rh_count", b0.o_stall_count, 32'd0);
    chk("rh_r5_cleared", b0.o_registers[5*DATA_W +: DATA_W], 32'd0);
    setin(1'b1, rtype(5'd2, 5'd3, 5'd4, 6'h20), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    #1 chk("rh_pc_write", b0.o_pc_write, 32'd1);
    tick();
    chk("rh_load_valid", b0.o_valid, 32'd1);
    chk("rh_load_rs", b0.o_rs_addr, 32'd2);

    for (int i = 0; i < 3000; i++) begin
      logic [5:0]  op;
      logic [31:0] ins;
      case ($urandom_range(0, 4))
        0:       op = 6'd0;
        1:       op = 6'd35;
        2:       op = 6'd43;
        3:       op = 6'd8;
        default: op = 6'($urandom);
      endcase
      ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      setin(($urandom_range(0, 9) < 8), ins, ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)),
            $urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 99) == 0));
      tick();
    end
    tick();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
